// File: rtl/branch_resolve_ctrl_if.sv
// Redirect handshake between the branch resolver and fetch.
interface branch_resolve_ctrl_if;
  logic        valid;
  logic [31:0] pc;
  logic        ready;

  modport master (output valid, output pc, input ready);
  modport slave  (input valid, input pc, output ready);
endinterface

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolver: waits for operands, drives the shared equality
// comparator, decides taken/not-taken and issues the fetch redirect.
module branch_resolve_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  br_valid,
  input  logic [2:0]            br_op,
  input  logic [31:0]           pc_id,
  input  logic [15:0]           imm16,
  input  logic [31:0]           rs_val,
  input  logic [31:0]           rt_val,
  input  logic                  rs_ready,
  input  logic                  rt_ready,
  input  logic                  flush,
  output logic [31:0]           cmp_a,
  output logic [31:0]           cmp_b,
  input  logic                  cmp_zero,
  output logic                  stall,
  output logic                  br_done,
  branch_resolve_ctrl_if.master redir,
  output logic                  illegal_op,
  output logic                  wait_timeout,
  output logic [CNT_W-1:0]      br_cnt,
  output logic [CNT_W-1:0]      taken_cnt
);

  localparam int WCW = $clog2(WAIT_MAX + 2);
  localparam logic [WCW-1:0] WSAT = WCW'(WAIT_MAX + 1);
  localparam logic [WCW-1:0] WHIT = WCW'(WAIT_MAX);

  typedef enum logic [1:0] {IDLE, WAIT, EVAL, REDIR} state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] pc;
    logic [15:0] imm;
  } br_lat_t;

  state_t         state;
  br_lat_t        lat;
  logic [WCW-1:0] wcnt;

  logic        two_op, ready, latch_go;
  logic        ev, taken, illegal, sgn;
  logic [31:0] tgt;

  assign two_op   = (br_op == 3'b000) || (br_op == 3'b001);
  assign ready    = rs_ready && (rt_ready || !two_op);
  assign latch_go = !flush && ready &&
                    (((state == IDLE) && br_valid) || (state == WAIT));

  // cmp_a holds the latched rs, so its sign bit is the operand sign.
  assign ev  = (state == EVAL);
  assign sgn = cmp_a[31];
  assign tgt = lat.pc + 32'd4 + {{14{lat.imm[15]}}, lat.imm, 2'b00};

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (lat.op)
      3'b000:  taken = cmp_zero;
      3'b001:  taken = !cmp_zero;
      3'b010:  taken = sgn || cmp_zero;
      3'b011:  taken = !sgn && !cmp_zero;
      3'b100:  taken = sgn;
      3'b101:  taken = !sgn;
      default: illegal = 1'b1;
    endcase
  end

  assign illegal_op = ev && illegal;
  assign br_done    = !flush && ((ev && !taken) || ((state == REDIR) && redir.ready));
  assign stall      = ((state == IDLE) && br_valid) || (state == WAIT) ||
                      (ev && taken) || ((state == REDIR) && !redir.ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      lat          <= '0;
      wcnt         <= '0;
      cmp_a        <= '0;
      cmp_b        <= '0;
      redir.valid  <= 1'b0;
      redir.pc     <= '0;
      wait_timeout <= 1'b0;
      br_cnt       <= '0;
      taken_cnt    <= '0;
    end else begin
      if (br_done) begin
        if (!(&br_cnt)) br_cnt <= br_cnt + CNT_W'(1);
        if ((state == REDIR) && !(&taken_cnt)) taken_cnt <= taken_cnt + CNT_W'(1);
      end

      if (latch_go) begin
        lat.op  <= br_op;
        lat.pc  <= pc_id;
        lat.imm <= imm16;
        cmp_a   <= rs_val;
        cmp_b   <= two_op ? rt_val : 32'd0;
      end

      if (flush) begin
        state       <= IDLE;
        redir.valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (br_valid) begin
            state <= ready ? EVAL : WAIT;
            wcnt  <= '0;
          end
          WAIT: begin
            if (wcnt != WSAT) wcnt <= wcnt + WCW'(1);
            if (wcnt == WHIT) wait_timeout <= 1'b1;
            if (ready) state <= EVAL;
          end
          EVAL: if (taken) begin
            redir.pc    <= tgt;
            redir.valid <= 1'b1;
            state       <= REDIR;
          end else begin
            state <= IDLE;
          end
          REDIR: if (redir.ready) begin
            redir.valid <= 1'b0;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench: default-width DUT plus a CNT_W=2 twin driven identically for saturation.
module tb_branch_resolve_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        br_valid, rs_ready, rt_ready, flush;
  logic [2:0]  br_op;
  logic [31:0] pc_id, rs_val, rt_val;
  logic [15:0] imm16;

  logic [31:0] cmp_a, cmp_b, cmp_a2, cmp_b2;
  logic        cmp_zero, cmp_zero2;
  logic        stall, br_done, illegal_op, wait_timeout;
  logic        stall2, br_done2, illegal_op2, wait_timeout2;
  logic [15:0] br_cnt, taken_cnt;
  logic [1:0]  br_cnt2, taken_cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  branch_resolve_ctrl_if rif ();
  branch_resolve_ctrl_if rif2 ();
  assign rif2.ready = rif.ready;

  // Comparator models the shared equality unit outside the block.
  assign cmp_zero  = (cmp_a == cmp_b);
  assign cmp_zero2 = (cmp_a2 == cmp_b2);

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.CNT_W(16), .WAIT_MAX(15)) u_dut (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_op(br_op), .pc_id(pc_id),
    .imm16(imm16), .rs_val(rs_val), .rt_val(rt_val), .rs_ready(rs_ready),
    .rt_ready(rt_ready), .flush(flush), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_zero(cmp_zero), .stall(stall), .br_done(br_done), .redir(rif.master),
    .illegal_op(illegal_op), .wait_timeout(wait_timeout), .br_cnt(br_cnt),
    .taken_cnt(taken_cnt)
  );

  branch_resolve_ctrl #(.CNT_W(2), .WAIT_MAX(15)) u_dut2 (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_op(br_op), .pc_id(pc_id),
    .imm16(imm16), .rs_val(rs_val), .rt_val(rt_val), .rs_ready(rs_ready),
    .rt_ready(rt_ready), .flush(flush), .cmp_a(cmp_a2), .cmp_b(cmp_b2),
    .cmp_zero(cmp_zero2), .stall(stall2), .br_done(br_done2), .redir(rif2.master),
    .illegal_op(illegal_op2), .wait_timeout(wait_timeout2), .br_cnt(br_cnt2),
    .taken_cnt(taken_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_cnt(input int b, input int t);
    chk("br_cnt", br_cnt, b);
    chk("taken_cnt", taken_cnt, t);
    chk("br_cnt_sat", br_cnt2, (b > 3) ? 3 : b);
    chk("taken_cnt_sat", taken_cnt2, (t > 3) ? 3 : t);
  endtask

  task automatic nxt;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge in IDLE; returns one cycle later with br_valid dropped.
  task automatic issue(input logic [2:0] op, input logic [31:0] pc, input logic [15:0] imm,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic rsr, input logic rtr);
    br_valid = 1'b1; br_op = op; pc_id = pc; imm16 = imm;
    rs_val = rs; rt_val = rt; rs_ready = rsr; rt_ready = rtr;
    #1 chk("idle_stall", stall, 1);
    nxt();
    br_valid = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b0; br_valid = 0; br_op = 0; pc_id = 0; imm16 = 0; rs_val = 0; rt_val = 0;
    rs_ready = 0; rt_ready = 0; flush = 0; rif.ready = 0;
    @(negedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_rvalid", rif.valid, 0);
    chk("rst_rpc", rif.pc, 0);
    chk("rst_cmp_a", cmp_a, 0);
    chk("rst_timeout", wait_timeout, 0);
    chk_cnt(0, 0);
    reset = 1'b1;
    @(negedge clk);

    // BEQ taken, fetch holds off for two cycles
    issue(3'b000, 32'h3000, 16'h0004, 32'h1234, 32'h1234, 1, 1);
    chk("beq_cmp_a", cmp_a, 32'h1234);
    chk("beq_cmp_b", cmp_b, 32'h1234);
    chk("beq_eval_stall", stall, 1);
    chk("beq_eval_done", br_done, 0);
    nxt(); #1;
    chk("beq_rvalid", rif.valid, 1);
    chk("beq_rpc", rif.pc, 32'h0000_3014);
    chk("beq_redir_stall", stall, 1);
    nxt(); #1;
    chk("beq_rpc_hold", rif.pc, 32'h0000_3014);
    rif.ready = 1'b1;
    #1 chk("beq_done", br_done, 1);
    chk("beq_acc_stall", stall, 0);
    nxt(); rif.ready = 1'b0; #1;
    chk("beq_rvalid_drop", rif.valid, 0);
    chk_cnt(1, 1);

    // BNE equal operands: not taken, single stall cycle
    issue(3'b001, 32'h3100, 16'h0010, 32'd5, 32'd5, 1, 1);
    chk("bne_eval_stall", stall, 0);
    chk("bne_done", br_done, 1);
    chk("bne_rvalid", rif.valid, 0);
    nxt(); #1;
    chk("bne_rvalid_after", rif.valid, 0);
    chk_cnt(2, 1);

    // BGTZ negative: not taken, cmp_b forced to zero
    issue(3'b011, 32'h3200, 16'h0010, 32'h8000_0000, 32'hDEAD_BEEF, 1, 0);
    chk("bgtz_cmp_b", cmp_b, 0);
    chk("bgtz_done", br_done, 1);
    nxt(); #1;
    chk_cnt(3, 1);

    // BLEZ zero: taken, negative offset, fetch ready at once
    rif.ready = 1'b1;
    issue(3'b010, 32'h0000_0100, 16'hFFFF, 32'd0, 32'd77, 1, 0);
    chk("blez_eval_stall", stall, 1);
    nxt(); #1;
    chk("blez_rpc", rif.pc, 32'h0000_0100);
    chk("blez_done", br_done, 1);
    nxt(); #1;
    chk_cnt(4, 2);

    // BGEZ positive with rt not ready: proceeds straight to EVAL
    issue(3'b101, 32'h0000_0200, 16'h0002, 32'd7, 32'd0, 1, 0);
    chk("bgez_eval_stall", stall, 1);
    nxt(); #1;
    chk("bgez_rpc", rif.pc, 32'h0000_020C);
    nxt(); #1;
    chk_cnt(5, 3);

    // BEQ with rs late for 20 cycles: timeout after 16 WAIT cycles
    issue(3'b000, 32'h0000_0400, 16'h0000, 32'd9, 32'd9, 0, 1);
    for (int k = 1; k <= 20; k++) begin
      nxt(); #1;
      if (k == 15) chk("wait_timeout_15", wait_timeout, 0);
      if (k == 16) chk("wait_timeout_16", wait_timeout, 1);
      if (k == 20) chk("wait_stall", stall, 1);
    end
    rs_ready = 1'b1;
    nxt(); #1;
    chk("wait_eval_stall", stall, 1);
    nxt(); #1;
    chk("wait_rpc", rif.pc, 32'h0000_0404);
    chk("wait_done", br_done, 1);
    nxt(); rif.ready = 1'b0; #1;
    chk_cnt(6, 4);

    // Taken branch flushed in REDIR while fetch finally accepts
    issue(3'b000, 32'h0000_0500, 16'h0003, 32'd1, 32'd1, 1, 1);
    for (int k = 0; k < 3; k++) nxt();
    #1 chk("fl_rvalid", rif.valid, 1);
    chk("fl_rpc", rif.pc, 32'h0000_0510);
    flush = 1'b1; rif.ready = 1'b1;
    #1 chk("fl_done", br_done, 0);
    nxt(); rif.ready = 1'b0;
    // flush in IDLE swallows a new taken BEQ
    br_valid = 1'b1; br_op = 3'b000; pc_id = 32'h600; rs_val = 32'd4; rt_val = 32'd4;
    #1 chk("fl_rvalid_drop", rif.valid, 0);
    nxt(); flush = 1'b0; br_valid = 1'b0;
    #1 chk("fl_ignored_stall", stall, 0);
    chk("fl_ignored_done", br_done, 0);
    chk("timeout_sticky", wait_timeout, 1);
    chk_cnt(6, 4);

    // PC wrap-around on the redirect target
    rif.ready = 1'b1;
    issue(3'b000, 32'hFFFF_FFF8, 16'h0001, 32'd2, 32'd2, 1, 1);
    nxt(); #1;
    chk("wrap_rpc", rif.pc, 32'h0000_0000);
    chk("wrap_done", br_done, 1);
    nxt(); rif.ready = 1'b0; #1;
    chk_cnt(7, 5);

    // Illegal op: not taken, illegal pulse, still retires
    issue(3'b110, 32'h0000_0800, 16'h0001, 32'd0, 32'd0, 1, 0);
    chk("ill_pulse", illegal_op, 1);
    chk("ill_done", br_done, 1);
    chk("ill_stall", stall, 0);
    nxt(); #1;
    chk("ill_pulse_end", illegal_op, 0);
    chk_cnt(8, 5);

    // Reset in the middle of a redirect aborts everything
    issue(3'b000, 32'h0000_0700, 16'h0000, 32'd3, 32'd3, 1, 1);
    nxt(); #1;
    chk("mr_rvalid", rif.valid, 1);
    reset = 1'b0;
    #1 chk("mr_rvalid_drop", rif.valid, 0);
    chk("mr_stall", stall, 0);
    chk("mr_timeout", wait_timeout, 0);
    chk_cnt(0, 0);
    reset = 1'b1;
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
